// File: rtl/blur_frame_ctrl_if.sv
// Pixel handshake bundle between the blur frame controller and its
// upstream source / downstream sink.
//   px_in_valid   : upstream has a pixel available
//   px_in_ready   : controller takes a real pixel this cycle
//   px_out_ready  : downstream accepts the output pixel
//   px_out_valid  : output register holds a pixel
//   px_out_last_x : output pixel is in the last column
//   px_out_last_y : output pixel is in the last row
// master = environment side, slave = controller side.
interface blur_frame_ctrl_if;
  logic px_in_valid;
  logic px_in_ready;
  logic px_out_ready;
  logic px_out_valid;
  logic px_out_last_x;
  logic px_out_last_y;

  modport master (
    output px_in_valid, px_out_ready,
    input  px_in_ready, px_out_valid, px_out_last_x, px_out_last_y
  );

  modport slave (
    input  px_in_valid, px_out_ready,
    output px_in_ready, px_out_valid, px_out_last_x, px_out_last_y
  );
endinterface

// File: rtl/blur_frame_ctrl.sv
// Raster sequencer for the 3x3 blur core. Walks an extended scan of
// (W+1)x(H+1) positions per frame, taking a real pixel or injecting a zero
// pad at each one, and tells the datapath when to shift, which line-buffer
// column to use and which window taps to mask. Owns the output handshake
// and the frame-done flag.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   cfg_width/height  : image size minus 1, latched in the idle cycle
//   px (slave)        : input/output pixel handshake
//   step, step_pad    : datapath shift strobe, with zero-pad select
//   step_col          : scan column (line-buffer address)
//   load_out          : datapath loads its output register
//   mask_*            : border taps to zero for the centre being loaded
//   done              : every output of the frame has been accepted
module blur_frame_ctrl #(
  parameter int XB = 10,
  parameter int YB = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [XB-1:0] cfg_width,
  input  logic [YB-1:0] cfg_height,
  blur_frame_ctrl_if.slave px,
  output logic          step,
  output logic          step_pad,
  output logic [XB:0]   step_col,
  output logic          load_out,
  output logic          mask_top,
  output logic          mask_bottom,
  output logic          mask_left,
  output logic          mask_right,
  output logic          done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [XB:0] X_ONE = (XB+1)'(1);
  localparam logic [YB:0] Y_ONE = (YB+1)'(1);

  logic [1:0]    r_state;
  logic [XB-1:0] r_cw;
  logic [YB-1:0] r_ch;
  logic [XB:0]   r_sx;
  logic [YB:0]   r_sy;
  logic          r_out_valid;
  logic          r_last_x;
  logic          r_last_y;

  logic [XB:0] w_cw_ext;
  logic [YB:0] w_ch_ext;
  logic [XB:0] w_sx_max;
  logic [YB:0] w_sy_max;
  logic [XB:0] w_cx;
  logic [YB:0] w_cy;
  logic        w_run;
  logic        w_pad;
  logic        w_emit;
  logic        w_out_ok;
  logic        w_step;
  logic        w_load;
  logic        w_final_accept;

  // Counters are one bit wider than the config so the pad column/row
  // (cw+1, ch+1) is representable even for a full 2**XB / 2**YB frame.
  assign w_cw_ext = {1'b0, r_cw};
  assign w_ch_ext = {1'b0, r_ch};
  assign w_sx_max = w_cw_ext + X_ONE;
  assign w_sy_max = w_ch_ext + Y_ONE;
  assign w_cx     = r_sx - X_ONE;
  assign w_cy     = r_sy - Y_ONE;

  assign w_run    = (r_state == S_RUN);
  assign w_pad    = (r_sx > w_cw_ext) | (r_sy > w_ch_ext);
  assign w_emit   = (r_sx != '0) & (r_sy != '0);
  assign w_out_ok = ~r_out_valid | px.px_out_ready;

  // A step that emits must not overwrite an output that is still held;
  // non-emitting steps proceed regardless of the output side.
  assign w_step = w_run & (~w_emit | w_out_ok) & (w_pad | px.px_in_valid);
  assign w_load = w_step & w_emit;

  assign w_final_accept = r_out_valid & px.px_out_ready & r_last_x & r_last_y;

  assign px.px_in_ready   = w_run & ~w_pad & (~w_emit | w_out_ok);
  assign px.px_out_valid  = r_out_valid;
  assign px.px_out_last_x = r_last_x;
  assign px.px_out_last_y = r_last_y;

  assign step        = w_step;
  assign step_pad    = w_step & w_pad;
  assign step_col    = r_sx;
  assign load_out    = w_load;
  assign mask_top    = w_load & (w_cy == '0);
  assign mask_bottom = w_load & (w_cy == w_ch_ext);
  assign mask_left   = w_load & (w_cx == '0);
  assign mask_right  = w_load & (w_cx == w_cw_ext);
  assign done        = (r_state == S_DONE);

  // Frame state and scan position. The scan ends on the step that consumes
  // the bottom-right pad corner; the final output is then drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cw    <= '0;
      r_ch    <= '0;
      r_sx    <= '0;
      r_sy    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cw    <= cfg_width;
          r_ch    <= cfg_height;
          r_sx    <= '0;
          r_sy    <= '0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (w_step) begin
            if (r_sx == w_sx_max) begin
              r_sx <= '0;
              if (r_sy == w_sy_max) begin
                r_sy    <= '0;
                r_state <= S_DRAIN;
              end else begin
                r_sy <= r_sy + Y_ONE;
              end
            end else begin
              r_sx <= r_sx + X_ONE;
            end
          end
        end
        S_DRAIN: begin
          if (w_final_accept) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Output register: a new load replaces the held pixel even in the cycle
  // it is accepted, giving one pixel per clock under continuous traffic.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_last_x    <= 1'b0;
      r_last_y    <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_last_x    <= (w_cx == w_cw_ext);
      r_last_y    <= (w_cy == w_ch_ext);
    end else if (r_out_valid & px.px_out_ready) begin
      r_out_valid <= 1'b0;
      r_last_x    <= 1'b0;
      r_last_y    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_blur_frame_ctrl.sv
module tb_blur_frame_ctrl;
  localparam int XB = 10;
  localparam int YB = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [XB-1:0] cfgWidth = '0;
  logic [YB-1:0] cfgHeight = '0;
  logic          step, stepPad, loadOut, done;
  logic          maskTop, maskBottom, maskLeft, maskRight;
  logic [XB:0]   stepCol;

  blur_frame_ctrl_if pxIf();

  blur_frame_ctrl #(.XB(XB), .YB(YB)) dut (
    .clk(clk), .rst(rst), .cfg_width(cfgWidth), .cfg_height(cfgHeight),
    .px(pxIf), .step(step), .step_pad(stepPad), .step_col(stepCol),
    .load_out(loadOut), .mask_top(maskTop), .mask_bottom(maskBottom),
    .mask_left(maskLeft), .mask_right(maskRight), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model state: the frame is a list of (W+1)*(H+1) scan positions and
  // W*H outputs in raster order; everything is derived from counts.
  int modelW = 1, modelH = 1;
  int postResetCycles = 0;
  int stepCount = 0;
  int outAccepts = 0;
  bit held = 0, heldLastX = 0, heldLastY = 0;

  // Statistics observed on the DUT, pinned by literal expectations.
  int dutSteps = 0, dutInAccepts = 0, dutPadSteps = 0, dutLoads = 0;
  int dutOutAccepts = 0, lastXCount = 0, bothLastCount = 0;
  int maskBottomCount = 0, maxCol = 0, lastStepCol = 0;
  int firstLoadStep = -1, inAcceptsAtFirstLoad = 0;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, then advance the model by
  // the events that the coming clock edge will commit.
  always @(negedge clk) begin : compareProc
    int total, sx, sy, cx, cy;
    bit pad, emit, running, outOk, eReady, eStep, eLoad, rdy;
    if (rst) begin
      modelW = int'(cfgWidth) + 1;
      modelH = int'(cfgHeight) + 1;
      postResetCycles = 0; stepCount = 0; outAccepts = 0;
      held = 0; heldLastX = 0; heldLastY = 0;
      dutSteps = 0; dutInAccepts = 0; dutPadSteps = 0; dutLoads = 0;
      dutOutAccepts = 0; lastXCount = 0; bothLastCount = 0;
      maskBottomCount = 0; maxCol = 0; lastStepCol = 0;
      firstLoadStep = -1; inAcceptsAtFirstLoad = 0;
    end else begin
      total   = (modelW + 1) * (modelH + 1);
      sx      = stepCount % (modelW + 1);
      sy      = stepCount / (modelW + 1);
      cx      = sx - 1;
      cy      = sy - 1;
      pad     = (sx == modelW) || (sy == modelH);
      emit    = (sx > 0) && (sy > 0);
      running = (postResetCycles >= 1) && (stepCount < total);
      rdy     = pxIf.px_out_ready;
      outOk   = !held || rdy;
      eReady  = running && !pad && (!emit || outOk);
      eStep   = running && (!emit || outOk) && (pad || pxIf.px_in_valid);
      eLoad   = eStep && emit;

      checkOutput("px_in_ready", 32'(pxIf.px_in_ready), 32'(eReady));
      checkOutput("step", 32'(step), 32'(eStep));
      checkOutput("step_pad", 32'(stepPad), 32'(eStep && pad));
      checkOutput("load_out", 32'(loadOut), 32'(eLoad));
      checkOutput("px_out_valid", 32'(pxIf.px_out_valid), 32'(held));
      checkOutput("done", 32'(done), 32'(outAccepts == modelW * modelH));
      if (held) begin
        checkOutput("last_x", 32'(pxIf.px_out_last_x), 32'(heldLastX));
        checkOutput("last_y", 32'(pxIf.px_out_last_y), 32'(heldLastY));
      end
      if (eStep) checkOutput("step_col", 32'(stepCol), sx);
      if (eLoad) begin
        checkOutput("mask_top", 32'(maskTop), 32'(cy == 0));
        checkOutput("mask_bottom", 32'(maskBottom), 32'(cy == modelH - 1));
        checkOutput("mask_left", 32'(maskLeft), 32'(cx == 0));
        checkOutput("mask_right", 32'(maskRight), 32'(cx == modelW - 1));
      end

      if (pxIf.px_in_ready && pxIf.px_in_valid) dutInAccepts++;
      if (step) begin
        if (int'(stepCol) > maxCol) maxCol = int'(stepCol);
        lastStepCol = int'(stepCol);
        if (stepPad) dutPadSteps++;
      end
      if (loadOut) begin
        if (firstLoadStep < 0) begin
          firstLoadStep = dutSteps;
          inAcceptsAtFirstLoad = dutInAccepts;
        end
        dutLoads++;
        if (maskBottom) maskBottomCount++;
      end
      if (step) dutSteps++;
      if (pxIf.px_out_valid && rdy) begin
        dutOutAccepts++;
        if (pxIf.px_out_last_x) lastXCount++;
        if (pxIf.px_out_last_x && pxIf.px_out_last_y) bothLastCount++;
      end

      if (held && rdy) outAccepts++;
      if (eLoad) begin
        held = 1;
        heldLastX = (cx == modelW - 1);
        heldLastY = (cy == modelH - 1);
      end else if (held && rdy) begin
        held = 0;
      end
      if (eStep) stepCount++;
      postResetCycles++;
    end
  end

  // Called at posedge+1: one reset cycle with the new size, then the idle
  // cycle in which every output must read 0.
  task automatic doReset(input int w, input int h);
    rst = 1'b1;
    cfgWidth = XB'(w - 1);
    cfgHeight = YB'(h - 1);
    pxIf.px_in_valid = 1'b0;
    pxIf.px_out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_in_ready", 32'(pxIf.px_in_ready), 0);
    checkOutput("rst_out_valid", 32'(pxIf.px_out_valid), 0);
    checkOutput("rst_last_xy", 32'({pxIf.px_out_last_x, pxIf.px_out_last_y}), 0);
    checkOutput("rst_step", 32'({step, stepPad, loadOut}), 0);
    checkOutput("rst_step_col", 32'(stepCol), 0);
    checkOutput("rst_masks", 32'({maskTop, maskBottom, maskLeft, maskRight}), 0);
    checkOutput("rst_done", 32'(done), 0);
    @(posedge clk); #1;
  endtask

  // inMode: 0 always valid, 1 toggling, 2 random.
  // outMode: 0 always ready, 1 random (75%).
  task automatic applyStimulus(input int inMode, input int outMode, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      case (inMode)
        0:       pxIf.px_in_valid = 1'b1;
        1:       pxIf.px_in_valid = n[0];
        default: pxIf.px_in_valid = 1'($urandom_range(0, 1));
      endcase
      pxIf.px_out_ready = (outMode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      n++;
    end
    if (n >= budget) checkOutput("frame_timeout", 32'(done), 1);
  endtask

  initial begin
    pxIf.px_in_valid = 1'b0;
    pxIf.px_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 4x4 at full rate
    doReset(4, 4);
    applyStimulus(0, 0, 500);
    checkOutput("f44_steps", dutSteps, 25);
    checkOutput("f44_in_accepts", dutInAccepts, 16);
    checkOutput("f44_pad_steps", dutPadSteps, 9);
    checkOutput("f44_first_load_step", firstLoadStep, 6);
    checkOutput("f44_accepts_at_first_load", inAcceptsAtFirstLoad, 6);
    checkOutput("f44_outputs", dutOutAccepts, 16);
    checkOutput("f44_last_xy", bothLastCount, 1);

    // 4x4 with the output stalled after the first load
    doReset(4, 4);
    begin
      int n = 0;
      while (dutLoads < 1 && n < 100) begin
        pxIf.px_in_valid = 1'b1;
        pxIf.px_out_ready = 1'b1;
        @(posedge clk); #1;
        n++;
      end
      if (n >= 100) checkOutput("stall_first_load_timeout", dutLoads, 1);
    end
    pxIf.px_out_ready = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    checkOutput("stall_valid", 32'(pxIf.px_out_valid), 1);
    checkOutput("stall_in_ready", 32'(pxIf.px_in_ready), 0);
    checkOutput("stall_loads", dutLoads, 1);
    checkOutput("stall_position", stepCount, 7);
    @(posedge clk); #1;
    applyStimulus(0, 0, 500);
    checkOutput("stall_outputs", dutOutAccepts, 16);

    // 1024x4 with toggling input valid
    doReset(1024, 4);
    applyStimulus(1, 0, 12000);
    checkOutput("wide_in_accepts", dutInAccepts, 4096);
    checkOutput("wide_pad_steps", dutPadSteps, 1029);
    checkOutput("wide_max_col", maxCol, 1024);
    checkOutput("wide_last_x_pulses", lastXCount, 4);

    // 4x1024 at full rate
    doReset(4, 1024);
    applyStimulus(0, 0, 8000);
    checkOutput("tall_steps", dutSteps, 5125);
    checkOutput("tall_pad_steps", dutPadSteps, 1029);
    checkOutput("tall_mask_bottom", maskBottomCount, 4);
    checkOutput("tall_last_col", lastStepCol, 4);

    // 1x1 frame, random traffic
    doReset(1, 1);
    applyStimulus(2, 1, 500);
    checkOutput("tiny_outputs", dutOutAccepts, 1);
    checkOutput("tiny_pad_steps", dutPadSteps, 3);

    // 7x5 frame, random traffic
    doReset(7, 5);
    applyStimulus(2, 1, 3000);
    checkOutput("rand_outputs", dutOutAccepts, 35);

    // Reset mid-frame while an output is held, then a fresh 5x4 frame
    doReset(6, 3);
    begin
      int n = 0;
      while (!(dutLoads >= 3 && pxIf.px_out_valid) && n < 500) begin
        pxIf.px_in_valid = 1'($urandom_range(0, 1));
        pxIf.px_out_ready = ($urandom_range(0, 3) == 0);
        @(posedge clk); #1;
        n++;
      end
      if (n >= 500) checkOutput("midrst_timeout", dutLoads, 3);
    end
    checkOutput("midrst_valid_before", 32'(pxIf.px_out_valid), 1);
    doReset(5, 4);
    applyStimulus(2, 1, 2000);
    checkOutput("midrst_outputs", dutOutAccepts, 20);
    checkOutput("midrst_in_accepts", dutInAccepts, 20);

    // Hold input valid after done
    pxIf.px_in_valid = 1'b1;
    pxIf.px_out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i % 25 == 0) begin
        checkOutput("post_done_in_ready", 32'(pxIf.px_in_ready), 0);
        checkOutput("post_done_out_valid", 32'(pxIf.px_out_valid), 0);
        checkOutput("post_done_done", 32'(done), 1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/blur_frame_ctrl.md
Name: blur_frame_ctrl

Overview:
- Raster sequencer for the 3x3 blur core behind `top`.
- Walks an extended scan of (W+1)x(H+1) positions per frame (W = cfg_width+1, H = cfg_height+1). For each position it either accepts a real input pixel or injects a zero pad pixel.
- Tells the blur datapath when to shift its window, which line-buffer column to use, and which border taps to mask.
- Owns the output handshake, including last_x/last_y, and the frame-done flag.

Parameters:
- XB, 10, bit width of the x dimension (width up to 2**XB).
- YB, 10, bit width of the y dimension (height up to 2**YB).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cfg_width  in  XB  image width minus 1; sampled on the first cycle after rst deasserts.
- cfg_height  in  YB  image height minus 1; sampled the same way.
- px_in_valid  in  1  upstream pixel valid.
- px_in_ready  out  1  controller takes a real pixel this cycle.
- px_out_ready  in  1  downstream accepts the output pixel.
- px_out_valid  out  1  output register holds a pixel.
- px_out_last_x  out  1  output pixel is in the last column.
- px_out_last_y  out  1  output pixel is in the last row.
- step  out  1  datapath shifts its window and writes the line buffer this cycle.
- step_pad  out  1  with step: datapath uses 0 instead of px_in_data.
- step_col  out  XB+1  scan column sx; line-buffer address.
- load_out  out  1  datapath loads its output data register this cycle (= step & emit).
- mask_top, mask_bottom, mask_left, mask_right  out  1 each  zero the corresponding window row or column for the centre being loaded; valid with load_out.
- done  out  1  all W*H outputs have been accepted.

Behaviour:
- Reset values: every output is 0, including px_in_ready and step; state=IDLE; sx=sy=0.
- FSM: IDLE -> RUN -> DRAIN -> DONE. rst forces IDLE from any state, discards any held output, and clears px_out_valid the next cycle.
- IDLE: lasts one cycle; latches cfg_width and cfg_height as cw and ch; goes to RUN.
- Scan position: sx in 0..cw+1, sy in 0..ch+1.
  - pad = (sx > cw) | (sy > ch).
  - emit = (sx >= 1) & (sy >= 1). The emitted centre is (cx, cy) = (sx-1, sy-1).
- out_ok = !px_out_valid | px_out_ready.
- px_in_ready = RUN & !pad & (!emit | out_ok). It is combinational from registered state and px_out_ready only, never from px_in_valid.
- step = RUN & (!emit | out_ok) & (pad | px_in_valid).
  - Steps with no emit and pad may fire while the output is stalled.
  - step_pad = step & pad.
- On step, the scan advances:
  - sx increments.
  - When sx == cw+1: sx wraps to 0 and sy increments.
  - When sx == cw+1 and sy == ch+1: go to DRAIN.
- On load_out:
  - px_out_valid <= 1.
  - px_out_last_x <= (cx == cw); px_out_last_y <= (cy == ch).
  - Masks: mask_top = (cy == 0), mask_bottom = (cy == ch), mask_left = (cx == 0), mask_right = (cx == cw).
- Output register:
  - px_out_ready & px_out_valid with no new load clears px_out_valid.
  - If a new load happens in the same cycle, px_out_valid stays 1 with the new contents; this gives back-to-back throughput of 1 pixel per clock.
- DRAIN: wait for acceptance of the final output (last_x & last_y); then go to DONE.
- DONE: done=1, held until rst. px_in_ready=0 and step=0.
- Latency: the output for centre (cx,cy) is loaded on the step that consumes position (cx+1, cy+1). With continuous traffic, the first output appears W+2 steps after the first input accept.
- Step counts per frame:
  - Total steps = (W+1)*(H+1).
  - Real input accepts = W*H exactly.
  - Pad steps = W+H+1.
- Counter widths: sx is XB+1 bits and sy is YB+1 bits, so W = 2**XB and H = 2**YB do not overflow.

Test Plan:
- 4x4 frame, in/out rate 100%: 25 steps, 16 px_in accepts, 9 step_pad. The first load_out happens on step index 6, after 6 accepts. 16 outputs; the last one has last_x=last_y=1. done is asserted 1 cycle after the final accept.
- 4x4 frame, px_out_ready held 0 after the first load: px_out_valid stays 1. No step fires with emit=1. px_in_ready drops to 0 at sx=2, sy=1. Releasing ready resumes with no pixel lost or duplicated.
- 1024x4 frame, input valid toggling every other cycle: exactly 4096 accepts and 1029 pad steps. step_col reaches 1024 without wrapping early. The last_x pulse count is 4.
- 4x1024 frame: sy reaches 1024 and the scan ends at sx=4, sy=1024. mask_bottom is set only for cy=1023.
- rst asserted mid-frame while px_out_valid=1: the next cycle has all outputs 0 and state IDLE. A new 5x4 frame with different cfg produces exactly 20 correct outputs and no stale pixel.
- After done, px_in_valid held 1 for 100 cycles: px_in_ready stays 0, px_out_valid stays 0, and done stays 1.
